// File: rtl/multicycle_insn_sequencer_if.sv
// Fetch, memory and datapath-control bundle of the multicycle sequencer.
// master = sequencer, slave = fetch/datapath/memory side.
interface multicycle_insn_sequencer_if;
    logic [31:0] insn;
    logic        insn_valid;
    logic        insn_ack_rdy;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        sub_sra;
    logic        addr_sel;
    logic        pc_next_sel;
    logic        pc_alu_sel;
    logic        rd_we;
    logic        insn_done;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  insn,
        input  insn_valid,
        input  mem_ready,
        output insn_ack_rdy,
        output mem_req,
        output mem_we,
        output sub_sra,
        output addr_sel,
        output pc_next_sel,
        output pc_alu_sel,
        output rd_we,
        output insn_done,
        output illegal,
        output state
    );

    modport slave (
        output insn,
        output insn_valid,
        output mem_ready,
        input  insn_ack_rdy,
        input  mem_req,
        input  mem_we,
        input  sub_sra,
        input  addr_sel,
        input  pc_next_sel,
        input  pc_alu_sel,
        input  rd_we,
        input  insn_done,
        input  illegal,
        input  state
    );
endinterface

// File: rtl/multicycle_insn_sequencer.sv
// RV32I multicycle control FSM: IDLE/DECODE/EXEC/MEM/WB/TRAP.
// MULTICYCLE_SEQ_TIMEOUT_EN enables the MEM wait timeout counter.
module multicycle_insn_sequencer #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic                         clk,
    input logic                         reset,
    multicycle_insn_sequencer_if.master bus
);

    if (XLEN < 32 || (2 ** CNT_W) <= MEM_TIMEOUT) begin : g_bad_cfg
        $error("multicycle_insn_sequencer: bad XLEN/CNT_W/MEM_TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t     state_q;
    logic [6:0] opc_q;
    logic [2:0] funct3_q;
    logic       b30_q;
    logic       is_mem_q;
    logic       is_store_q;
    logic       wr_rd_q;

    logic ack_q;
    logic mem_req_q;
    logic mem_we_q;
    logic sub_sra_q;
    logic addr_sel_q;
    logic pc_next_sel_q;
    logic pc_alu_sel_q;
    logic rd_we_q;
    logic done_q;
    logic ill_q;

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
`endif

    // Only the opcode, funct3 and bit 30 steer control; the rest of
    // the word belongs to the datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            opc_q         <= '0;
            funct3_q      <= '0;
            b30_q         <= 1'b0;
            is_mem_q      <= 1'b0;
            is_store_q    <= 1'b0;
            wr_rd_q       <= 1'b0;
            ack_q         <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            sub_sra_q     <= 1'b0;
            addr_sel_q    <= 1'b0;
            pc_next_sel_q <= 1'b0;
            pc_alu_sel_q  <= 1'b0;
            rd_we_q       <= 1'b0;
            done_q        <= 1'b0;
            ill_q         <= 1'b0;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            ack_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            rd_we_q   <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (ack_q && bus.insn_valid) begin
                        opc_q    <= bus.insn[6:0];
                        funct3_q <= bus.insn[14:12];
                        b30_q    <= bus.insn[30];
                        ill_q    <= 1'b0;
                        state_q  <= S_DECODE;
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q       <= S_EXEC;
                    is_mem_q      <= 1'b0;
                    is_store_q    <= 1'b0;
                    wr_rd_q       <= 1'b1;
                    sub_sra_q     <= 1'b0;
                    addr_sel_q    <= 1'b0;
                    pc_next_sel_q <= 1'b0;
                    pc_alu_sel_q  <= 1'b0;
                    unique case (1'b1)
                        (opc_q == OPC_LUI),
                        (opc_q == OPC_AUIPC): begin
                        end
                        (opc_q == OPC_JAL): begin
                            pc_next_sel_q <= 1'b1;
                        end
                        (opc_q == OPC_JALR): begin
                            pc_alu_sel_q  <= 1'b1;
                            pc_next_sel_q <= 1'b1;
                        end
                        (opc_q == OPC_BRANCH): begin
                            sub_sra_q <= 1'b1;
                            wr_rd_q   <= 1'b0;
                        end
                        (opc_q == OPC_LOAD): begin
                            pc_alu_sel_q <= 1'b1;
                            addr_sel_q   <= 1'b1;
                            is_mem_q     <= 1'b1;
                        end
                        (opc_q == OPC_STORE): begin
                            pc_alu_sel_q <= 1'b1;
                            addr_sel_q   <= 1'b1;
                            is_mem_q     <= 1'b1;
                            is_store_q   <= 1'b1;
                            wr_rd_q      <= 1'b0;
                        end
                        (opc_q == OPC_OP): begin
                            pc_alu_sel_q <= 1'b1;
                            sub_sra_q    <= b30_q;
                        end
                        (opc_q == OPC_OPIMM): begin
                            pc_alu_sel_q <= 1'b1;
                            sub_sra_q    <= b30_q && (funct3_q == 3'b101);
                        end
                        default: begin
                            ill_q   <= 1'b1;
                            wr_rd_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_TRAP;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (is_mem_q) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= is_store_q;
                        state_q   <= S_MEM;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end else begin
                        done_q  <= 1'b1;
                        rd_we_q <= wr_rd_q;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        done_q  <= 1'b1;
                        rd_we_q <= wr_rd_q;
                        state_q <= S_WB;
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        ill_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= is_store_q;
                    end
`else
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= is_store_q;
                    end
`endif
                end
                S_WB, S_TRAP: begin
                    ack_q         <= 1'b1;
                    sub_sra_q     <= 1'b0;
                    addr_sel_q    <= 1'b0;
                    pc_next_sel_q <= 1'b0;
                    pc_alu_sel_q  <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.insn_ack_rdy = ack_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.sub_sra      = sub_sra_q;
    assign bus.addr_sel     = addr_sel_q;
    assign bus.pc_next_sel  = pc_next_sel_q;
    assign bus.pc_alu_sel   = pc_alu_sel_q;
    assign bus.rd_we        = rd_we_q;
    assign bus.insn_done    = done_q;
    assign bus.illegal      = ill_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_insn_sequencer.sv
// Directed scoreboard bench for multicycle_insn_sequencer.
// Completions are queued at accept and checked on insn_done.
module tb_multicycle_insn_sequencer;

    logic clk;
    logic reset;

    multicycle_insn_sequencer_if bus ();

    multicycle_insn_sequencer #(
        .XLEN        (32),
        .MEM_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rd_we;
        logic ill;
        int   lat;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   mreq_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.insn_ack_rdy, bus.mem_req, bus.mem_we, bus.sub_sra,
                bus.addr_sel, bus.pc_next_sel, bus.pc_alu_sel, bus.rd_we,
                bus.insn_done, bus.illegal, bus.state};
    endfunction

    function automatic logic [3:0] sel_vec();
        return {bus.sub_sra, bus.addr_sel, bus.pc_next_sel, bus.pc_alu_sel};
    endfunction

    task automatic pop_check();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_rd_we", bus.rd_we, e.rd_we);
            chk("done_illegal", bus.illegal, e.ill);
            chk("done_latency", cyc - e.acc + 1, e.lat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_req) mreq_cnt++;
        if (bus.insn_done) pop_check();
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!bus.insn_ack_rdy && n < 10) begin
            tick();
            n++;
        end
        chk("ack_rdy", bus.insn_ack_rdy, 1);
    endtask

    task automatic issue(input logic [31:0] w, input logic [3:0] sel,
                         input logic rdw, input logic ill, input int lat,
                         input logic mem, input logic we, input int nwait,
                         input logic noise);
        exp_t e;
        wait_ack();
        bus.insn       = w;
        bus.insn_valid = 1'b1;
        mreq_cnt       = 0;
        tick();
        e.rd_we = rdw;
        e.ill   = ill;
        e.lat   = lat;
        e.acc   = cyc;
        sb.push_back(e);
        if (noise) bus.insn = 32'h0000007F;
        else bus.insn_valid = 1'b0;
        chk("decode_state", bus.state, 1);
        chk("ill_cleared", bus.illegal, 0);
        chk("ack_busy", bus.insn_ack_rdy, 0);
        tick();
        if (ill) begin
            chk("trap_state", bus.state, 5);
            chk("trap_rd_we", bus.rd_we, 0);
        end else begin
            chk("exec_state", bus.state, 2);
            chk("exec_sel", sel_vec(), sel);
            if (mem) begin
                tick();
                chk("mem_state", bus.state, 3);
                chk("mem_we", bus.mem_we, we);
                for (int i = 0; i < nwait; i++) begin
                    tick();
                    chk("mem_hold", bus.state, 3);
                end
            end
            if (mem || noise) bus.mem_ready = 1'b1;
            tick();
            chk("wb_state", bus.state, 4);
            chk("wb_sel", sel_vec(), sel);
            bus.mem_ready  = 1'b0;
            bus.insn_valid = 1'b0;
        end
        tick();
        chk("idle_state", bus.state, 0);
        chk("idle_sel", sel_vec(), 0);
        chk("ill_after", bus.illegal, ill);
        chk("mreq_cycles", mreq_cnt, mem ? nwait + 1 : 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.insn       = '0;
        bus.insn_valid = 1'b0;
        bus.mem_ready  = 1'b0;
        #1;
        chk("reset_outs", all_outs(), 0);
        #13;
        reset = 1'b0;
        tick();
        chk("post_reset_ack", bus.insn_ack_rdy, 1);
        chk("post_reset_state", bus.state, 0);

        // auipc, lw (2 waits), sw (no wait), sub
        issue(32'h12345117, 4'b0000, 1, 0, 3, 0, 0, 0, 0);
        issue(32'h0000A103, 4'b0101, 1, 0, 6, 1, 0, 2, 0);
        issue(32'h0020A023, 4'b0101, 0, 0, 4, 1, 1, 0, 0);
        issue(32'h40208033, 4'b1001, 1, 0, 3, 0, 0, 0, 0);
        // illegal opcode, then next accept clears illegal
        issue(32'h0000007F, 4'b0000, 0, 1, 2, 0, 0, 0, 0);
        issue(32'h0000006F, 4'b0010, 1, 0, 3, 0, 0, 0, 0);
        issue(32'h00208463, 4'b1000, 0, 0, 3, 0, 0, 0, 0);
        issue(32'h4010D093, 4'b1001, 1, 0, 3, 0, 0, 0, 0);
        issue(32'h40008093, 4'b0001, 1, 0, 3, 0, 0, 0, 0);
        issue(32'h000080E7, 4'b0011, 1, 0, 3, 0, 0, 0, 0);
        // lui with stray insn_valid/mem_ready while busy
        issue(32'h123450B7, 4'b0000, 1, 0, 3, 0, 0, 0, 1);

        // reset while in MEM
        wait_ack();
        bus.insn       = 32'h0000A103;
        bus.insn_valid = 1'b1;
        tick();
        bus.insn_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_mem_req", bus.mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        repeat (3) tick();
        chk("reset_held_outs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("reset_rel_ack", bus.insn_ack_rdy, 1);

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        begin
            exp_t e;
            int   n;
            wait_ack();
            bus.insn       = 32'h0000A103;
            bus.insn_valid = 1'b1;
            mreq_cnt       = 0;
            tick();
            bus.insn_valid = 1'b0;
            e.rd_we = 0;
            e.ill   = 1;
            e.lat   = 19;
            e.acc   = cyc;
            sb.push_back(e);
            n = 0;
            while (sb.size() != 0 && n < 40) begin
                tick();
                n++;
            end
            chk("timeout_done", sb.size(), 0);
            chk("timeout_state", bus.state, 5);
            chk("timeout_mem_req", bus.mem_req, 0);
            tick();
            chk("timeout_ill", bus.illegal, 1);
            chk("timeout_mreq_cycles", mreq_cnt, 16);
        end
`else
        issue(32'h0000A103, 4'b0101, 1, 0, 24, 1, 0, 20, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
